// File: rtl/xform_transpose_apply.sv
// xform_transpose_apply
//
// Applies the transpose of a spatial transform to a 6-vector force during the
// backward sweep: f_parent = X^T * f_child, where X = [E 0; B E] is supplied as
// the 15 sparse entries produced by the transform generator. The three entries
// the generator never produces (E_AZ_AX, B_LZ_AY, B_LZ_AZ) are taken as zero.
//
// A single signed multiplier is time-shared over a fixed 23-step MAC schedule.
// Each output is accumulated at full precision and rounded once, with floor
// rounding, on its last term.
//
// Ports
//   clk, reset_n            clock, synchronous active-low reset
//   in_valid / in_ready     operand handshake; in_ready is high only when idle
//   xform_in_<ROW>_<COL>    15 transform entries, X[row][col]
//   f_in_AX..f_in_AZ        child force, angular part n
//   f_in_LX..f_in_LZ        child force, linear part fL
//   out_valid / out_ready   result handshake; out_valid holds until accepted
//   f_out_AX..f_out_LZ      parent-frame force

module xform_transpose_apply #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DECIMAL_BITS = 16
) (
  input  logic             clk,
  input  logic             reset_n,

  input  logic             in_valid,
  output logic             in_ready,

  input  logic [WIDTH-1:0] xform_in_AX_AX,
  input  logic [WIDTH-1:0] xform_in_AX_AY,
  input  logic [WIDTH-1:0] xform_in_AX_AZ,
  input  logic [WIDTH-1:0] xform_in_AY_AX,
  input  logic [WIDTH-1:0] xform_in_AY_AY,
  input  logic [WIDTH-1:0] xform_in_AY_AZ,
  input  logic [WIDTH-1:0] xform_in_AZ_AY,
  input  logic [WIDTH-1:0] xform_in_AZ_AZ,
  input  logic [WIDTH-1:0] xform_in_LX_AX,
  input  logic [WIDTH-1:0] xform_in_LX_AY,
  input  logic [WIDTH-1:0] xform_in_LX_AZ,
  input  logic [WIDTH-1:0] xform_in_LY_AX,
  input  logic [WIDTH-1:0] xform_in_LY_AY,
  input  logic [WIDTH-1:0] xform_in_LY_AZ,
  input  logic [WIDTH-1:0] xform_in_LZ_AX,

  input  logic [WIDTH-1:0] f_in_AX,
  input  logic [WIDTH-1:0] f_in_AY,
  input  logic [WIDTH-1:0] f_in_AZ,
  input  logic [WIDTH-1:0] f_in_LX,
  input  logic [WIDTH-1:0] f_in_LY,
  input  logic [WIDTH-1:0] f_in_LZ,

  output logic             out_valid,
  input  logic             out_ready,

  output logic [WIDTH-1:0] f_out_AX,
  output logic [WIDTH-1:0] f_out_AY,
  output logic [WIDTH-1:0] f_out_AZ,
  output logic [WIDTH-1:0] f_out_LX,
  output logic [WIDTH-1:0] f_out_LY,
  output logic [WIDTH-1:0] f_out_LZ
);

  // Two headroom bits would cover five terms; one more keeps the sum safe
  // even with every product at its most negative value.
  localparam int unsigned AccW     = 2 * WIDTH + 3;
  localparam logic [4:0]  LastStep = 5'd22;

  // Coefficient slots in latch order.
  localparam logic [3:0] CAxAx = 4'd0;
  localparam logic [3:0] CAxAy = 4'd1;
  localparam logic [3:0] CAxAz = 4'd2;
  localparam logic [3:0] CAyAx = 4'd3;
  localparam logic [3:0] CAyAy = 4'd4;
  localparam logic [3:0] CAyAz = 4'd5;
  localparam logic [3:0] CAzAy = 4'd6;
  localparam logic [3:0] CAzAz = 4'd7;
  localparam logic [3:0] CLxAx = 4'd8;
  localparam logic [3:0] CLxAy = 4'd9;
  localparam logic [3:0] CLxAz = 4'd10;
  localparam logic [3:0] CLyAx = 4'd11;
  localparam logic [3:0] CLyAy = 4'd12;
  localparam logic [3:0] CLyAz = 4'd13;
  localparam logic [3:0] CLzAx = 4'd14;

  // Force operand slots: n = 0..2, fL = 3..5. Also used as output slots.
  localparam logic [2:0] VnX = 3'd0;
  localparam logic [2:0] VnY = 3'd1;
  localparam logic [2:0] VnZ = 3'd2;
  localparam logic [2:0] VfX = 3'd3;
  localparam logic [2:0] VfY = 3'd4;
  localparam logic [2:0] VfZ = 3'd5;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                  state_q;
  logic [4:0]              step_q;
  logic signed [AccW-1:0]  acc_q;
  logic                    out_valid_q;
  logic signed [WIDTH-1:0] out_q [6];
  logic signed [WIDTH-1:0] xf_q  [15];
  logic signed [WIDTH-1:0] f_q   [6];

  // Step schedule decode.
  logic [3:0] coef_sel;
  logic [2:0] opnd_sel;
  logic [2:0] out_sel;
  logic       first_term;
  logic       last_term;

  always_comb begin
    coef_sel   = CAxAx;
    opnd_sel   = VnX;
    out_sel    = 3'd0;
    first_term = 1'b0;
    last_term  = 1'b0;
    case (step_q)
      // f_out_AX
      5'd0:  begin coef_sel = CAxAx; opnd_sel = VnX; first_term = 1'b1; end
      5'd1:  begin coef_sel = CAyAx; opnd_sel = VnY; end
      5'd2:  begin coef_sel = CLxAx; opnd_sel = VfX; end
      5'd3:  begin coef_sel = CLyAx; opnd_sel = VfY; end
      5'd4:  begin coef_sel = CLzAx; opnd_sel = VfZ; last_term = 1'b1; out_sel = 3'd0; end
      // f_out_AY
      5'd5:  begin coef_sel = CAxAy; opnd_sel = VnX; first_term = 1'b1; end
      5'd6:  begin coef_sel = CAyAy; opnd_sel = VnY; end
      5'd7:  begin coef_sel = CAzAy; opnd_sel = VnZ; end
      5'd8:  begin coef_sel = CLxAy; opnd_sel = VfX; end
      5'd9:  begin coef_sel = CLyAy; opnd_sel = VfY; last_term = 1'b1; out_sel = 3'd1; end
      // f_out_AZ
      5'd10: begin coef_sel = CAxAz; opnd_sel = VnX; first_term = 1'b1; end
      5'd11: begin coef_sel = CAyAz; opnd_sel = VnY; end
      5'd12: begin coef_sel = CAzAz; opnd_sel = VnZ; end
      5'd13: begin coef_sel = CLxAz; opnd_sel = VfX; end
      5'd14: begin coef_sel = CLyAz; opnd_sel = VfY; last_term = 1'b1; out_sel = 3'd2; end
      // f_out_LX
      5'd15: begin coef_sel = CAxAx; opnd_sel = VfX; first_term = 1'b1; end
      5'd16: begin coef_sel = CAyAx; opnd_sel = VfY; last_term = 1'b1; out_sel = 3'd3; end
      // f_out_LY
      5'd17: begin coef_sel = CAxAy; opnd_sel = VfX; first_term = 1'b1; end
      5'd18: begin coef_sel = CAyAy; opnd_sel = VfY; end
      5'd19: begin coef_sel = CAzAy; opnd_sel = VfZ; last_term = 1'b1; out_sel = 3'd4; end
      // f_out_LZ
      5'd20: begin coef_sel = CAxAz; opnd_sel = VfX; first_term = 1'b1; end
      5'd21: begin coef_sel = CAyAz; opnd_sel = VfY; end
      5'd22: begin coef_sel = CAzAz; opnd_sel = VfZ; last_term = 1'b1; out_sel = 3'd5; end
      default: ;
    endcase
  end

  // Shared multiplier and accumulator datapath.
  logic signed [WIDTH-1:0]   coef;
  logic signed [WIDTH-1:0]   opnd;
  logic signed [2*WIDTH-1:0] coef_ext;
  logic signed [2*WIDTH-1:0] opnd_ext;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [AccW-1:0]    prod_ext;
  logic signed [AccW-1:0]    acc_sum;
  logic signed [AccW-1:0]    acc_shift;
  logic [WIDTH-1:0]          result_word;
  logic                      unused_shift_bits;

  always_comb begin
    coef     = xf_q[coef_sel];
    opnd     = f_q[opnd_sel];
    // Sign-extend before multiplying so the low 2*WIDTH bits are the exact product.
    coef_ext = {{WIDTH{coef[WIDTH-1]}}, coef};
    opnd_ext = {{WIDTH{opnd[WIDTH-1]}}, opnd};
    prod     = coef_ext * opnd_ext;
    prod_ext = {{3{prod[2*WIDTH-1]}}, prod};
    acc_sum  = (first_term ? '0 : acc_q) + prod_ext;
    // Arithmetic shift gives floor rounding; upper bits are dropped (wrap).
    acc_shift   = acc_sum >>> DECIMAL_BITS;
    result_word = acc_shift[WIDTH-1:0];
  end

  assign unused_shift_bits = ^acc_shift[AccW-1:WIDTH];

  // Control FSM and all state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      step_q      <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      for (int k = 0; k < 6; k++) begin
        out_q[k] <= '0;
        f_q[k]   <= '0;
      end
      for (int k = 0; k < 15; k++) begin
        xf_q[k] <= '0;
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            xf_q[CAxAx] <= xform_in_AX_AX;
            xf_q[CAxAy] <= xform_in_AX_AY;
            xf_q[CAxAz] <= xform_in_AX_AZ;
            xf_q[CAyAx] <= xform_in_AY_AX;
            xf_q[CAyAy] <= xform_in_AY_AY;
            xf_q[CAyAz] <= xform_in_AY_AZ;
            xf_q[CAzAy] <= xform_in_AZ_AY;
            xf_q[CAzAz] <= xform_in_AZ_AZ;
            xf_q[CLxAx] <= xform_in_LX_AX;
            xf_q[CLxAy] <= xform_in_LX_AY;
            xf_q[CLxAz] <= xform_in_LX_AZ;
            xf_q[CLyAx] <= xform_in_LY_AX;
            xf_q[CLyAy] <= xform_in_LY_AY;
            xf_q[CLyAz] <= xform_in_LY_AZ;
            xf_q[CLzAx] <= xform_in_LZ_AX;
            f_q[VnX]    <= f_in_AX;
            f_q[VnY]    <= f_in_AY;
            f_q[VnZ]    <= f_in_AZ;
            f_q[VfX]    <= f_in_LX;
            f_q[VfY]    <= f_in_LY;
            f_q[VfZ]    <= f_in_LZ;
            step_q      <= '0;
            state_q     <= StRun;
          end
        end
        StRun: begin
          acc_q <= acc_sum;
          if (last_term) begin
            out_q[out_sel] <= result_word;
          end
          if (step_q == LastStep) begin
            step_q      <= '0;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            step_q <= step_q + 5'd1;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign f_out_AX  = out_q[0];
  assign f_out_AY  = out_q[1];
  assign f_out_AZ  = out_q[2];
  assign f_out_LX  = out_q[3];
  assign f_out_LY  = out_q[4];
  assign f_out_LZ  = out_q[5];

endmodule

// File: tb/tb_xform_transpose_apply.sv
// Bench for xform_transpose_apply: directed steps with a scoreboard queue of
// expected 6-vectors, checked by immediate assertions.

module tb_xform_transpose_apply;

  logic clk       = 1'b0;
  logic reset_n   = 1'b0;
  logic in_valid  = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready;
  logic out_valid;

  logic signed [31:0] xf [15];
  logic signed [31:0] fv [6];
  logic [31:0]        fo [6];

  int checks      = 0;
  int failures    = 0;
  int cyc         = 0;
  int accept_cyc  = 0;
  int prev_accept = 0;

  logic [191:0] exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  xform_transpose_apply #(
    .WIDTH       (32),
    .DECIMAL_BITS(16)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .xform_in_AX_AX(xf[0]),
    .xform_in_AX_AY(xf[1]),
    .xform_in_AX_AZ(xf[2]),
    .xform_in_AY_AX(xf[3]),
    .xform_in_AY_AY(xf[4]),
    .xform_in_AY_AZ(xf[5]),
    .xform_in_AZ_AY(xf[6]),
    .xform_in_AZ_AZ(xf[7]),
    .xform_in_LX_AX(xf[8]),
    .xform_in_LX_AY(xf[9]),
    .xform_in_LX_AZ(xf[10]),
    .xform_in_LY_AX(xf[11]),
    .xform_in_LY_AY(xf[12]),
    .xform_in_LY_AZ(xf[13]),
    .xform_in_LZ_AX(xf[14]),
    .f_in_AX       (fv[0]),
    .f_in_AY       (fv[1]),
    .f_in_AZ       (fv[2]),
    .f_in_LX       (fv[3]),
    .f_in_LY       (fv[4]),
    .f_in_LZ       (fv[5]),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .f_out_AX      (fo[0]),
    .f_out_AY      (fo[1]),
    .f_out_AZ      (fo[2]),
    .f_out_LX      (fo[3]),
    .f_out_LY      (fo[4]),
    .f_out_LZ      (fo[5])
  );

  function automatic logic [191:0] pack6(input logic [31:0] a0, input logic [31:0] a1,
                                         input logic [31:0] a2, input logic [31:0] a3,
                                         input logic [31:0] a4, input logic [31:0] a5);
    return {a5, a4, a3, a2, a1, a0};
  endfunction

  // Reference: build the full 6x6 X (m[row][col]) and form X^T * f directly.
  function automatic logic [191:0] model();
    logic signed [31:0] m [6][6];
    logic signed [66:0] acc;
    logic signed [66:0] a;
    logic signed [66:0] b;
    logic signed [66:0] sh;
    logic [191:0]       r;
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++) m[i][j] = '0;
    m[0][0] = xf[0];  m[0][1] = xf[1];  m[0][2] = xf[2];
    m[1][0] = xf[3];  m[1][1] = xf[4];  m[1][2] = xf[5];
    m[2][1] = xf[6];  m[2][2] = xf[7];
    m[3][0] = xf[8];  m[3][1] = xf[9];  m[3][2] = xf[10];
    m[4][0] = xf[11]; m[4][1] = xf[12]; m[4][2] = xf[13];
    m[5][0] = xf[14];
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) m[3+i][3+j] = m[i][j];
    r = '0;
    for (int i = 0; i < 6; i++) begin
      acc = '0;
      for (int j = 0; j < 6; j++) begin
        a   = {{35{m[j][i][31]}}, m[j][i]};
        b   = {{35{fv[j][31]}}, fv[j]};
        acc = acc + a * b;
      end
      sh = acc >>> 16;
      r[i*32 +: 32] = sh[31:0];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [191:0] exp);
    for (int k = 0; k < 6; k++) chk($sformatf("%s[%0d]", tag, k), fo[k], exp[k*32 +: 32]);
  endtask

  task automatic clear_ops();
    for (int k = 0; k < 15; k++) xf[k] = '0;
    for (int k = 0; k < 6; k++) fv[k] = '0;
  endtask

  task automatic random_ops(input bit full_range);
    for (int k = 0; k < 15; k++)
      xf[k] = full_range ? $urandom() : $signed($urandom_range(262143)) - 131072;
    for (int k = 0; k < 6; k++)
      fv[k] = full_range ? $urandom() : $signed($urandom_range(1048575)) - 524288;
  endtask

  // Offer the current operands; the expected result is pushed at acceptance.
  // Operands are scrambled afterwards so a DUT that fails to latch them shows up.
  task automatic send(input bit keep_valid, input bit use_model, input logic [191:0] exp);
    int n;
    logic [191:0] e;
    n = 0;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk_bit("in_ready_before_accept", in_ready, 1'b1);
    e = use_model ? model() : exp;
    @(posedge clk); #1;
    accept_cyc = cyc;
    exp_q.push_back(e);
    chk_bit("in_ready_after_accept", in_ready, 1'b0);
    if (!keep_valid) in_valid = 1'b0;
    random_ops(1'b1);
  endtask

  // Wait for the result, compare, optionally stall, then complete the handshake.
  task automatic receive(input int hold, input bit keep_valid);
    int n;
    logic [191:0] e;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk_bit("out_valid_arrives", out_valid, 1'b1);
    chk("latency", cyc - accept_cyc, 32'd23);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_empty observed=0 entries expected=1 entry");
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    chk_vec("f_out", e);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk_bit("hold_out_valid", out_valid, 1'b1);
      chk_bit("hold_in_ready", in_ready, 1'b0);
      chk_vec("hold_f_out", e);
    end
    out_ready = 1'b1;
    if (!keep_valid) in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk_bit("out_valid_after_accept", out_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_ops();
    // Reset state
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk_bit("reset_out_valid", out_valid, 1'b0);
    chk_bit("reset_in_ready", in_ready, 1'b1);
    chk_vec("reset_f_out", '0);

    // 1: identity rotation
    clear_ops();
    xf[0] = 65536; xf[4] = 65536; xf[7] = 65536;
    for (int k = 0; k < 6; k++) fv[k] = (k + 1) * 65536;
    send(1'b0, 1'b0, pack6(65536, 131072, 196608, 262144, 327680, 393216));
    receive(0, 1'b0);

    // 2: link-1 transform at q=0
    clear_ops();
    xf[0] = 65536; xf[5] = 65536; xf[6] = -65536; xf[9] = 14123; xf[14] = 14123;
    fv[3] = 65536;
    send(1'b0, 1'b0, pack6(0, 14123, 0, 65536, 0, 0));
    receive(0, 1'b0);

    // 3: floor rounding of a negative one-LSB product
    clear_ops();
    xf[0] = -1; fv[0] = 1;
    send(1'b0, 1'b0, pack6(32'hFFFF_FFFF, 0, 0, 0, 0, 0));
    receive(0, 1'b0);

    // Random operands, moderate and full range (wrap)
    random_ops(1'b0);
    send(1'b0, 1'b1, '0);
    receive(0, 1'b0);
    random_ops(1'b1);
    send(1'b0, 1'b1, '0);
    receive(0, 1'b0);

    // 4: stall in DONE for 10 clocks with in_valid held high
    random_ops(1'b0);
    send(1'b0, 1'b1, '0);
    random_ops(1'b0);
    in_valid = 1'b1;
    receive(10, 1'b0);
    repeat (30) @(posedge clk);
    #1;
    chk_bit("nothing_taken_during_done", out_valid, 1'b0);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    // 5: reset in the middle of a run
    clear_ops();
    xf[0] = 65536; xf[4] = 65536; xf[7] = 65536;
    for (int k = 0; k < 6; k++) fv[k] = (k + 1) * 65536;
    send(1'b0, 1'b0, '0);
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    exp_q.delete();
    chk_bit("midrun_reset_out_valid", out_valid, 1'b0);
    chk_bit("midrun_reset_in_ready", in_ready, 1'b1);
    repeat (30) @(posedge clk);
    #1;
    chk_bit("midrun_reset_no_result", out_valid, 1'b0);
    clear_ops();
    xf[0] = 65536; xf[4] = 65536; xf[7] = 65536;
    for (int k = 0; k < 6; k++) fv[k] = (k + 1) * 65536;
    send(1'b0, 1'b0, pack6(65536, 131072, 196608, 262144, 327680, 393216));
    receive(0, 1'b0);

    // 6: back-to-back transactions, 25-clock period
    for (int t = 0; t < 3; t++) begin
      random_ops(1'b0);
      send(1'b1, 1'b1, '0);
      if (t > 0) chk("b2b_period", accept_cyc - prev_accept, 32'd25);
      prev_accept = accept_cyc;
      receive(0, t < 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
